// File: rtl/gray_word_deserializer_pkg.sv
// Shared constants and FSM encoding for the DIF Gray-word deserializer.
package gray_word_deserializer_pkg;

    localparam int DIF_GRAY_W          = 12;
    localparam int DIF_WORDS_PER_FRAME = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } dif_state_e;

endpackage

// File: rtl/gray_word_deserializer_fifo2.sv
// Two-entry first-word-fall-through valid/ready buffer; simultaneous push and
// pop are both honoured even when full, a push into a full buffer without a pop is dropped.
module dif_word_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         ready_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         drop_o
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop;

    assign valid_o = (count_q != 2'd0);
    assign dout_o  = head_q;
    assign pop     = valid_o & ready_i;
    assign drop_o  = push_i & (count_q == 2'd2) & ~pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = din_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = din_i;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gray_word_deserializer.sv
// Assembles the MSB-first serial Gray stream into framed parallel words and
// hands them downstream through a two-entry valid/ready buffer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a frame start; serial bits ignored
// ST_SHIFT | shifting bits of the current frame into words
module gray_word_deserializer
    import gray_word_deserializer_pkg::*;
#(
    parameter int WORD_W          = DIF_GRAY_W,
    parameter int WORDS_PER_FRAME = DIF_WORDS_PER_FRAME,
    parameter int IDX_W           = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Frame_Start,
    input  logic              In_Ser_En,
    input  logic              In_Ser_Data,
    input  logic              In_Ready,
    input  logic              In_Clear_Err,
    output logic [WORD_W-1:0] Out_Gray,
    output logic              Out_Valid,
    output logic [IDX_W-1:0]  Out_Word_Idx,
    output logic              Out_Last,
    output logic              Out_Busy,
    output logic              Out_Ovf,
    output logic              Out_Trunc
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int ENT_W = WORD_W + IDX_W + 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS_PER_FRAME - 1);

    dif_state_e         state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
    logic               pend_vld_q, pend_vld_d;
    logic [ENT_W-1:0]   pend_ent_q, pend_ent_d;
    logic               ovf_q, ovf_d;
    logic               trunc_q, trunc_d;

    logic [WORD_W-1:0]  word_full;
    logic               start, bit_done, frame_done, trunc_set;
    logic [ENT_W-1:0]   head_ent;
    logic               fifo_drop;

    assign word_full  = {shreg_q[WORD_W-2:0], In_Ser_Data};
    assign start      = In_Ser_En & In_Frame_Start;
    assign bit_done   = In_Ser_En & (state_q == ST_SHIFT) & (bit_cnt_q == BIT_LAST);
    assign frame_done = bit_done & (word_cnt_q == WORD_LAST);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        pend_vld_d = 1'b0;
        pend_ent_d = pend_ent_q;
        trunc_set  = 1'b0;

        // A start coinciding with the last bit of a frame still delivers that word.
        if (bit_done && (!start || frame_done)) begin
            pend_vld_d = 1'b1;
            pend_ent_d = {word_full, word_cnt_q, (word_cnt_q == WORD_LAST)};
        end

        if (start) begin
            trunc_set  = (state_q == ST_SHIFT) && !frame_done &&
                         ((bit_cnt_q != '0) || (word_cnt_q != '0));
            state_d    = ST_SHIFT;
            shreg_d    = WORD_W'(In_Ser_Data);
            bit_cnt_d  = BIT_W'(1);
            word_cnt_d = '0;
        end else if (In_Ser_En && (state_q == ST_SHIFT)) begin
            shreg_d = word_full;
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d = '0;
                if (word_cnt_q == WORD_LAST) begin
                    word_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    assign ovf_d   = (ovf_q & ~In_Clear_Err) | fifo_drop;
    assign trunc_d = (trunc_q & ~In_Clear_Err) | trunc_set;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            pend_vld_q <= 1'b0;
            pend_ent_q <= '0;
            ovf_q      <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            pend_vld_q <= pend_vld_d;
            pend_ent_q <= pend_ent_d;
            ovf_q      <= ovf_d;
            trunc_q    <= trunc_d;
        end
    end

    dif_word_fifo2 #(
        .W (ENT_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (pend_vld_q),
        .din_i   (pend_ent_q),
        .ready_i (In_Ready),
        .dout_o  (head_ent),
        .valid_o (Out_Valid),
        .drop_o  (fifo_drop)
    );

    assign Out_Gray     = head_ent[ENT_W-1 -: WORD_W];
    assign Out_Word_Idx = head_ent[IDX_W:1];
    assign Out_Last     = head_ent[0];
    assign Out_Busy     = (state_q == ST_SHIFT);
    assign Out_Ovf      = ovf_q;
    assign Out_Trunc    = trunc_q;

endmodule

// File: tb/tb_gray_word_deserializer.sv
// Scoreboard bench for gray_word_deserializer: expected words are queued as
// they are serialised and compared as the DUT hands them over.
module tb_gray_word_deserializer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_Frame_Start = 1'b0;
    logic        In_Ser_En = 1'b0;
    logic        In_Ser_Data = 1'b0;
    logic        In_Ready = 1'b0;
    logic        In_Clear_Err = 1'b0;
    logic [11:0] Out_Gray;
    logic        Out_Valid;
    logic [3:0]  Out_Word_Idx;
    logic        Out_Last;
    logic        Out_Busy;
    logic        Out_Ovf;
    logic        Out_Trunc;

    gray_word_deserializer #(
        .WORD_W          (12),
        .WORDS_PER_FRAME (16),
        .IDX_W           (4)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .In_Frame_Start (In_Frame_Start),
        .In_Ser_En      (In_Ser_En),
        .In_Ser_Data    (In_Ser_Data),
        .In_Ready       (In_Ready),
        .In_Clear_Err   (In_Clear_Err),
        .Out_Gray       (Out_Gray),
        .Out_Valid      (Out_Valid),
        .Out_Word_Idx   (Out_Word_Idx),
        .Out_Last       (Out_Last),
        .Out_Busy       (Out_Busy),
        .Out_Ovf        (Out_Ovf),
        .Out_Trunc      (Out_Trunc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] gray;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] frame_w [16];
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic fs);
        In_Ser_En      = 1'b1;
        In_Ser_Data    = b;
        In_Frame_Start = fs;
        tick();
        In_Ser_En      = 1'b0;
        In_Frame_Start = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] w, input logic fs, input bit stall);
        for (int i = 11; i >= 0; i--) begin
            drive_bit(w[i], fs && (i == 11));
            if (stall) tick();
        end
    endtask

    task automatic push_exp(input int k);
        exp_t e;
        e.gray = frame_w[k];
        e.idx  = 4'(k);
        e.last = (k == 15);
        sb.push_back(e);
    endtask

    task automatic send_words(input int from, input int to, input bit fs_first,
                              input bit expect_out, input bit stall);
        for (int k = from; k <= to; k++) begin
            if (expect_out) push_exp(k);
            send_word(frame_w[k], fs_first && (k == from), stall);
        end
    endtask

    task automatic random_frame();
        for (int k = 0; k < 16; k++) frame_w[k] = 12'($urandom);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic clear_err();
        In_Clear_Err = 1'b1;
        tick();
        In_Clear_Err = 1'b0;
    endtask

    // Handshake is decided at the next rising edge; inputs only move just after rising edges.
    initial begin
        forever begin
            @(negedge Clk);
            if (!Rst && Out_Valid && In_Ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {20'd0, Out_Gray}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_gray", {20'd0, Out_Gray}, {20'd0, e.gray});
                    check("word_idx",  {28'd0, Out_Word_Idx}, {28'd0, e.idx});
                    check("word_last", {31'd0, Out_Last}, {31'd0, e.last});
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs",
              {12'd0, Out_Valid, Out_Gray, Out_Word_Idx, Out_Last, Out_Busy, Out_Ovf, Out_Trunc}, 32'd0);
        Rst = 1'b0;
        tick();

        // Bits outside a frame are ignored.
        In_Ready = 1'b1;
        for (int i = 0; i < 12; i++) drive_bit(1'b1, 1'b0);
        check("idle_ignore_busy", {31'd0, Out_Busy}, 32'd0);

        // Basic frame 0x000..0x00F.
        for (int k = 0; k < 16; k++) frame_w[k] = 12'(k);
        send_words(0, 0, 1, 1, 0);
        check("basic_busy", {31'd0, Out_Busy}, 32'd1);
        send_words(1, 15, 0, 1, 0);
        check("basic_busy_drop", {31'd0, Out_Busy}, 32'd0);
        wait_drain("basic_drain");
        check("basic_flags", {30'd0, Out_Ovf, Out_Trunc}, 32'd0);

        // Latency with enable toggling; word 0 = 0xA5C.
        random_frame();
        frame_w[0] = 12'hA5C;
        push_exp(0);
        for (int i = 11; i >= 0; i--) begin
            drive_bit(frame_w[0][i], i == 11);
            if (i != 0) tick();
        end
        check("lat_not_early", {31'd0, Out_Valid}, 32'd0);
        tick();
        check("lat_valid", {31'd0, Out_Valid}, 32'd1);
        check("lat_gray", {20'd0, Out_Gray}, 32'hA5C);
        send_words(1, 15, 0, 1, 1);
        wait_drain("lat_drain");

        // Backpressure: third word dropped.
        In_Ready = 1'b0;
        random_frame();
        frame_w[0] = 12'h111;
        frame_w[1] = 12'h222;
        frame_w[2] = 12'h333;
        push_exp(0);
        push_exp(1);
        send_words(0, 2, 1, 0, 0);
        tick();
        tick();
        check("bp_ovf", {31'd0, Out_Ovf}, 32'd1);
        check("bp_hold", {19'd0, Out_Valid, Out_Gray}, {19'd0, 1'b1, 12'h111});
        In_Ready = 1'b1;
        wait_drain("bp_drain");
        clear_err();
        check("bp_ovf_clear", {31'd0, Out_Ovf}, 32'd0);
        send_words(3, 15, 0, 1, 0);
        wait_drain("bp_tail_drain");

        // Push and pop on the same edge while full.
        In_Ready = 1'b0;
        random_frame();
        send_words(0, 1, 1, 1, 0);
        check("full_head", {19'd0, Out_Valid, Out_Gray}, {19'd0, 1'b1, frame_w[0]});
        push_exp(2);
        send_word(frame_w[2], 1'b0, 1'b0);
        In_Ready = 1'b1;
        send_words(3, 15, 0, 1, 0);
        wait_drain("full_drain");
        check("full_no_ovf", {31'd0, Out_Ovf}, 32'd0);

        // Truncation after 5 bits of word 3.
        random_frame();
        send_words(0, 2, 1, 1, 0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        random_frame();
        send_words(0, 0, 1, 1, 0);
        check("trunc_set", {31'd0, Out_Trunc}, 32'd1);
        clear_err();
        check("trunc_clear", {31'd0, Out_Trunc}, 32'd0);
        send_words(1, 14, 0, 1, 0);
        // Frame start on the final bit of word 15 is not a truncation.
        push_exp(15);
        for (int i = 11; i >= 1; i--) drive_bit(frame_w[15][i], 1'b0);
        drive_bit(frame_w[15][0], 1'b1);
        check("coinc_busy", {31'd0, Out_Busy}, 32'd1);
        wait_drain("coinc_drain");
        check("coinc_no_trunc", {31'd0, Out_Trunc}, 32'd0);

        Rst = 1'b1;
        #2;
        Rst = 1'b0;
        tick();

        // Async reset mid-frame with two words buffered.
        In_Ready = 1'b0;
        random_frame();
        send_words(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b0);
        check("rst_pre_valid", {31'd0, Out_Valid}, 32'd1);
        #3;
        Rst = 1'b1;
        #1;
        check("rst_async_outputs",
              {12'd0, Out_Valid, Out_Gray, Out_Word_Idx, Out_Last, Out_Busy, Out_Ovf, Out_Trunc}, 32'd0);
        sb.delete();
        #2;
        Rst = 1'b0;
        tick();
        In_Ready = 1'b1;
        for (int i = 0; i < 24; i++) drive_bit(1'($urandom), 1'b0);
        check("rst_ignore", {30'd0, Out_Valid, Out_Busy}, 32'd0);
        random_frame();
        send_words(0, 15, 1, 1, 0);
        wait_drain("rst_recover_drain");
        check("rst_recover_idle", {29'd0, Out_Busy, Out_Ovf, Out_Trunc}, 32'd0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
